// File: rtl/maze_pellet_map.sv
// Pellet store for the maze: refill scan seeded from the wall lookup, eat port,
// registered renderer read port, pellet count and level-clear pulse.
module maze_pellet_map #(
  parameter int MAP_W = 27,
  parameter int MAP_H = 24,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          refill_start,
  output logic          busy,
  output logic [XW-1:0] map_x,
  output logic [YW-1:0] map_y,
  input  logic          map_wall,
  input  logic          eat_valid,
  input  logic [XW-1:0] eat_x,
  input  logic [YW-1:0] eat_y,
  output logic          eat_hit,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rd_pellet,
  output logic [CW-1:0] pellets_left,
  output logic          level_clear
);

  localparam int N  = MAP_W * MAP_H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [XW-1:0] LAST_X   = XW'(MAP_W - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [N-1:0]  pellet;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] eat_idx;
  logic [IW-1:0] rd_idx;
  logic          eat_ok;
  logic          rd_ok;

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (32'(x) < 32'(MAP_W)) && (32'(y) < 32'(MAP_H));
  endfunction

  // Only meaningful when in_range holds for the same coordinates.
  function automatic logic [IW-1:0] idx_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(32'(y) * 32'(MAP_W) + 32'(x));
  endfunction

  assign eat_ok  = eat_valid && in_range(eat_x, eat_y);
  assign rd_ok   = in_range(rd_x, rd_y);
  assign eat_idx = idx_of(eat_x, eat_y);
  assign rd_idx  = idx_of(rd_x, rd_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pellet       <= '0;
      scan_idx     <= '0;
      busy         <= 1'b0;
      map_x        <= '0;
      map_y        <= '0;
      eat_hit      <= 1'b0;
      level_clear  <= 1'b0;
      rd_pellet    <= 1'b0;
      pellets_left <= '0;
    end else begin
      eat_hit     <= 1'b0;
      level_clear <= 1'b0;
      // Read uses the pre-edge array, so a same-cycle write to this tile is not seen.
      rd_pellet   <= rd_ok ? pellet[rd_idx] : 1'b0;

      case (state)
        IDLE: begin
          if (refill_start) begin
            state        <= SCAN;
            busy         <= 1'b1;
            map_x        <= '0;
            map_y        <= '0;
            scan_idx     <= '0;
            pellets_left <= '0;
          end else if (eat_ok && pellet[eat_idx]) begin
            pellet[eat_idx] <= 1'b0;
            pellets_left    <= pellets_left - CW'(1);
            eat_hit         <= 1'b1;
            level_clear     <= (pellets_left == CW'(1));
          end
        end

        SCAN: begin
          pellet[scan_idx] <= ~map_wall;
          if (!map_wall) pellets_left <= pellets_left + CW'(1);
          if (scan_idx == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
            map_x <= '0;
            map_y <= '0;
          end else begin
            scan_idx <= scan_idx + IW'(1);
            if (map_x == LAST_X) begin
              map_x <= '0;
              map_y <= map_y + YW'(1);
            end else begin
              map_x <= map_x + XW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_pellet_map.sv
// Directed bench for maze_pellet_map: full-size instance with a stub wall map
// and a 5x3 all-open instance.
module tb_maze_pellet_map;

  logic       clk = 1'b0;
  logic       reset;
  int         total  = 0;
  int         passed = 0;
  int         mode   = 0;
  int         cnt;
  int         bad;

  // Full-size instance
  logic       refill_start, busy, map_wall, eat_valid, eat_hit, rd_pellet, level_clear;
  logic [7:0] map_x, eat_x, rd_x;
  logic [6:0] map_y, eat_y, rd_y;
  logic [9:0] pellets_left;

  // 5x3 instance
  logic       sm_refill, sm_busy, sm_wall, sm_eat_valid, sm_eat_hit, sm_rd_pellet, sm_level_clear;
  logic [7:0] sm_map_x, sm_eat_x, sm_rd_x;
  logic [6:0] sm_map_y, sm_eat_y, sm_rd_y;
  logic [3:0] sm_pellets_left;

  always #5 clk = ~clk;

  always_comb begin
    if (mode == 0) map_wall = (map_x == 8'd0) || (map_y == 7'd0);
    else           map_wall = !((map_x == 8'd1) && (map_y == 7'd1));
  end
  assign sm_wall = 1'b0;

  maze_pellet_map dut (
    .clk(clk), .reset(reset), .refill_start(refill_start), .busy(busy),
    .map_x(map_x), .map_y(map_y), .map_wall(map_wall),
    .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y), .eat_hit(eat_hit),
    .rd_x(rd_x), .rd_y(rd_y), .rd_pellet(rd_pellet),
    .pellets_left(pellets_left), .level_clear(level_clear)
  );

  maze_pellet_map #(.MAP_W(5), .MAP_H(3), .XW(8), .YW(7), .CW(4)) dut_sm (
    .clk(clk), .reset(reset), .refill_start(sm_refill), .busy(sm_busy),
    .map_x(sm_map_x), .map_y(sm_map_y), .map_wall(sm_wall),
    .eat_valid(sm_eat_valid), .eat_x(sm_eat_x), .eat_y(sm_eat_y), .eat_hit(sm_eat_hit),
    .rd_x(sm_rd_x), .rd_y(sm_rd_y), .rd_pellet(sm_rd_pellet),
    .pellets_left(sm_pellets_left), .level_clear(sm_level_clear)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Pulse refill on the full-size instance and return the number of busy samples.
  task automatic run_refill(output int n);
    refill_start = 1'b1;
    tick();
    refill_start = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    refill_start = 1'b0; eat_valid = 1'b0; eat_x = '0; eat_y = '0; rd_x = 8'd3; rd_y = 7'd4;
    sm_refill = 1'b0; sm_eat_valid = 1'b0; sm_eat_x = '0; sm_eat_y = '0; sm_rd_x = '0; sm_rd_y = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_pellets", pellets_left, 0);
    check("rst_rd", rd_pellet, 0);
    check("rst_eat_hit", eat_hit, 0);
    check("rst_level_clear", level_clear, 0);
    check("rst_map_x", map_x, 0);
    tick();
    check("no_auto_refill", busy, 0);

    // Refill with wall = (x==0)||(y==0); refill_start held on the final scan cycle
    refill_start = 1'b1;
    tick();
    refill_start = 1'b0;
    check("scan_busy_rise", busy, 1);
    check("scan_map_x0", map_x, 0);
    check("scan_map_y0", map_y, 0);
    check("scan_count_clear", pellets_left, 0);
    cnt = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      refill_start = (cnt == 648);
      tick();
    end
    refill_start = 1'b0;
    check("scan_busy_cycles", cnt, 648);
    check("scan_pellets", pellets_left, 598);
    tick();
    check("refill_on_last_ignored", busy, 0);
    check("idle_map_y", map_y, 0);

    rd_x = 8'd0; rd_y = 7'd5;
    tick();
    rd_x = 8'd3; rd_y = 7'd4;
    check("rd_wall_0_5", rd_pellet, 0);
    tick();
    check("rd_open_3_4", rd_pellet, 1);

    // Back-to-back eats of the same tile
    eat_valid = 1'b1; eat_x = 8'd3; eat_y = 7'd4;
    tick();
    check("eat1_hit", eat_hit, 1);
    check("eat1_pellets", pellets_left, 597);
    check("eat1_no_clear", level_clear, 0);
    tick();
    eat_valid = 1'b0;
    check("eat2_miss", eat_hit, 0);
    check("eat2_pellets", pellets_left, 597);
    tick();
    check("rd_eaten_3_4", rd_pellet, 0);

    // Same-cycle read and eat on (3,5): read sees pre-eat contents
    rd_x = 8'd3; rd_y = 7'd5; eat_valid = 1'b1; eat_x = 8'd3; eat_y = 7'd5;
    tick();
    eat_valid = 1'b0;
    check("rbw_rd", rd_pellet, 1);
    check("rbw_hit", eat_hit, 1);
    check("rbw_pellets", pellets_left, 596);
    tick();
    check("rbw_rd_after", rd_pellet, 0);

    eat_valid = 1'b1; eat_x = 8'd0; eat_y = 7'd5;
    tick();
    check("eat_wall_hit", eat_hit, 0);
    check("eat_wall_pellets", pellets_left, 596);
    eat_x = 8'd30; eat_y = 7'd4;
    tick();
    check("eat_oor_hit", eat_hit, 0);
    check("eat_oor_pellets", pellets_left, 596);
    eat_x = 8'd3; eat_y = 7'd24;
    tick();
    eat_valid = 1'b0;
    check("eat_oor_y_hit", eat_hit, 0);
    check("eat_oor_y_pellets", pellets_left, 596);

    // Reset 100 cycles into a scan
    refill_start = 1'b1;
    tick();
    refill_start = 1'b0;
    repeat (100) tick();
    check("midscan_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_pellets", pellets_left, 0);
    check("abort_map_x", map_x, 0);
    rd_x = 8'd1; rd_y = 7'd1;
    tick();
    rd_x = 8'd2; rd_y = 7'd1;
    check("abort_rd_1_1", rd_pellet, 0);
    tick();
    rd_x = 8'd5; rd_y = 7'd3;
    check("abort_rd_2_1", rd_pellet, 0);
    tick();
    check("abort_rd_5_3", rd_pellet, 0);
    run_refill(cnt);
    check("rescan_cycles", cnt, 648);
    check("rescan_pellets", pellets_left, 598);

    // Only (1,1) open: eating it clears the level
    mode = 1;
    run_refill(cnt);
    check("single_pellets", pellets_left, 1);
    eat_valid = 1'b1; eat_x = 8'd1; eat_y = 7'd1;
    tick();
    eat_valid = 1'b0;
    check("clear_hit", eat_hit, 1);
    check("clear_pulse", level_clear, 1);
    check("clear_pellets", pellets_left, 0);
    tick();
    check("clear_pulse_end", level_clear, 0);
    check("clear_hit_end", eat_hit, 0);
    check("clear_no_underflow", pellets_left, 0);

    // 5x3 all-open instance, eats attempted throughout the scan
    sm_refill = 1'b1;
    tick();
    sm_refill = 1'b0;
    sm_eat_valid = 1'b1; sm_eat_x = 8'd1; sm_eat_y = 7'd1;
    cnt = 0;
    bad = 0;
    while (sm_busy && cnt < 100) begin
      cnt++;
      if (sm_eat_hit) bad++;
      tick();
    end
    sm_eat_valid = 1'b0;
    check("sm_busy_cycles", cnt, 15);
    check("sm_eat_hits_while_busy", bad, 0);
    check("sm_eat_hit_last", sm_eat_hit, 0);
    check("sm_pellets", sm_pellets_left, 15);
    sm_rd_x = 8'd1; sm_rd_y = 7'd1;
    tick();
    check("sm_rd_1_1", sm_rd_pellet, 1);
    sm_eat_valid = 1'b1; sm_eat_x = 8'd4; sm_eat_y = 7'd2;
    tick();
    sm_eat_valid = 1'b0;
    check("sm_eat_last_tile", sm_eat_hit, 1);
    check("sm_pellets_after", sm_pellets_left, 14);
    sm_eat_valid = 1'b1; sm_eat_x = 8'd5; sm_eat_y = 7'd0;
    tick();
    sm_eat_valid = 1'b0;
    check("sm_eat_oor_x", sm_eat_hit, 0);
    check("sm_pellets_oor", sm_pellets_left, 14);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/maze_pellet_map.md
# maze_pellet_map

Stateful successor to the static maze wall lookup: a parametrised MAP_W × MAP_H tile store that tracks which tiles still hold a pellet. A refill sequencer scans the wall lookup once per level and seeds a pellet on every non-wall tile. Game logic clears pellets as Pac-Man eats them, the VGA renderer reads pellet state through a registered port, and the block reports the pellet count and a level-clear pulse. It sits between the maze wall lookup, the player/game FSM and the renderer.

## Interface
Parameters:
- MAP_W, 27, maze width in tiles
- MAP_H, 24, maze height in tiles
- XW, 8, x-coordinate width
- YW, 7, y-coordinate width
- CW, 10, pellet-counter width; must hold MAP_W*MAP_H

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- refill_start  in  1  request a pellet refill scan
- busy  out  1  refill scan in progress
- map_x  out  XW  scan x address to wall lookup
- map_y  out  YW  scan y address to wall lookup
- map_wall  in  1  wall bit for (map_x, map_y); combinational, same cycle
- eat_valid  in  1  clear the pellet at (eat_x, eat_y)
- eat_x  in  XW  eat tile x
- eat_y  in  YW  eat tile y
- eat_hit  out  1  registered; the last eat removed a pellet
- rd_x  in  XW  renderer read x
- rd_y  in  YW  renderer read y
- rd_pellet  out  1  registered pellet bit for (rd_x, rd_y)
- pellets_left  out  CW  pellets remaining
- level_clear  out  1  one-cycle pulse when the count reaches 0 by eating

## Operation
- Storage: N = MAP_W*MAP_H bits, index = y*MAP_W + x. Coordinates with x ≥ MAP_W or y ≥ MAP_H are out of range.
- FSM states:
  - IDLE: busy=0; map_x and map_y hold 0.
  - SCAN: busy=1; one tile per cycle, x inner loop, y outer loop.
- Transitions:
  - IDLE→SCAN on refill_start. The scan pointer is set to (0,0) and pellets_left is cleared to 0.
  - SCAN→IDLE after tile (MAP_W-1, MAP_H-1) is written.
- SCAN cycle: write pellet[idx] = ~map_wall. pellets_left increments by 1 when ~map_wall. The pointer then advances (x wraps to 0 and y increments at x = MAP_W-1).
- Eat (IDLE only, in range): if pellet[idx] = 1, clear it, decrement pellets_left, and set eat_hit=1 next cycle; otherwise eat_hit=0. If that decrement takes the count 1→0, pulse level_clear on the same cycle as eat_hit.
- Ignored inputs:
  - refill_start while busy is ignored.
  - eat_valid while busy is ignored (eat_hit=0).
  - An out-of-range eat is ignored (eat_hit=0).
- Read port: rd_pellet = pellet[idx] registered, or 0 if out of range. It reads pre-write contents (read-before-write) when a same-cycle eat or scan write hits the same tile.
- Eating a tile with no pellet never changes pellets_left; no underflow.
- Reset: all pellet bits=0, FSM→IDLE, busy=0, map_x=map_y=0, eat_hit=0, rd_pellet=0, pellets_left=0, level_clear=0. No automatic refill after reset.
- Reset asserted mid-SCAN aborts the scan and applies all reset values in the following cycle.

## Timing
- refill_start sampled high at edge t (in IDLE):
  - busy=1 and (map_x, map_y)=(0,0) from t+1.
  - Tile k is written at edge t+1+k.
  - busy stays high for exactly N cycles; it falls, with pellets_left final, after edge t+N.
- A refill_start coincident with the final SCAN cycle is ignored.
- Eat: latency 1 cycle. eat_hit, level_clear and the new pellets_left are all visible at t+1.
- Read: latency 1 cycle, with a fully pipelined address (a new address every cycle).
- Throughput: one eat per cycle. Back-to-back eats of the same tile produce hit then miss.

## Test plan
- Wall stub model wall = (x==0)||(y==0), default parameters. Pulse refill_start → busy high for 648 cycles; pellets_left=598; rd at (0,5) → 0; rd at (3,4) → 1.
- After refill, eat (3,4) twice on consecutive cycles → eat_hit 1 then 0; pellets_left 597, then stays 597; rd (3,4) → 0.
- Eat (0,5) (wall) and (30,4) (out of range) → eat_hit=0; pellets_left unchanged.
- Wall stub with only tile (1,1) open → after refill pellets_left=1; eat (1,1) → level_clear single pulse with eat_hit=1 at t+1; pellets_left=0.
- Assert reset 100 cycles into a SCAN → next cycle busy=0, pellets_left=0, all rd_pellet reads 0. A new refill then completes normally (598).
- Parameter sweep MAP_W=5, MAP_H=3, CW=4, all-open walls → busy 15 cycles; pellets_left=15. Eats issued while busy → eat_hit=0 and no state change.
